// File: rtl/dlx_bus_slave_mem_if.sv
// Asynchronous-strobe DLX bus between the core (master) and a memory responder (slave).
interface dlx_bus_slave_mem_if;
  logic        AS_N;
  logic        WR_N;
  logic [31:0] ADDR;
  logic [31:0] DI;
  logic [31:0] DO;
  logic        ACK_N;
  logic        BUSY;
  logic [1:0]  SLV_STATE;

  modport master (
    output AS_N, WR_N, ADDR, DI,
    input  DO, ACK_N, BUSY, SLV_STATE
  );

  modport slave (
    input  AS_N, WR_N, ADDR, DI,
    output DO, ACK_N, BUSY, SLV_STATE
  );
endinterface

// File: rtl/dlx_bus_slave_mem.sv
// Word RAM answering DLX strobe cycles inside an aligned address window,
// with a programmable wait-state count and a one-cycle registered ACK_N.
module dlx_bus_slave_mem #(
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 2
) (
  input logic              CLK_IN,
  input logic              RESET_IN,
  dlx_bus_slave_mem_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       mem [DEPTH];
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx_q;
  logic              wr_n_q;
  logic [31:0]       di_q;
  logic              hit;
  logic              start;
  logic              go_ack;
  logic              unused_addr_lsb;

  assign hit             = (bus.ADDR[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign unused_addr_lsb = ^bus.ADDR[1:0];

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    go_ack    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.AS_N && hit) begin
          start     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.AS_N) begin
          state_nxt = S_IDLE;
        end else if (cnt == '0) begin
          go_ack    = 1'b1;
          state_nxt = S_ACK;
        end
      end
      S_ACK:     state_nxt = S_RELEASE;
      S_RELEASE: if (bus.AS_N) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Address, direction and data are captured once in IDLE; WAIT ignores bus changes.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      cnt       <= '0;
      idx_q     <= '0;
      wr_n_q    <= 1'b1;
      di_q      <= '0;
      bus.ACK_N <= 1'b1;
      bus.DO    <= '0;
    end else begin
      if (start) begin
        idx_q  <= bus.ADDR[ADDR_W+1:2];
        wr_n_q <= bus.WR_N;
        di_q   <= bus.DI;
        cnt    <= 4'(WAIT_STATES);
      end else if (state == S_WAIT && !bus.AS_N && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end

      if (go_ack) begin
        bus.ACK_N <= 1'b0;
        bus.DO    <= wr_n_q ? mem[idx_q] : '0;
      end else if (state == S_ACK) begin
        bus.ACK_N <= 1'b1;
        bus.DO    <= '0;
      end
    end
  end

  // RAM survives reset; a reset forces IDLE, which suppresses go_ack.
  always_ff @(posedge CLK_IN) begin
    if (go_ack && !wr_n_q) mem[idx_q] <= di_q;
  end

  assign bus.BUSY      = (state != S_IDLE);
  assign bus.SLV_STATE = state;

endmodule
